// File: rtl/stereo_decorrelator_pkg.sv
// Shared FLAC channel-assignment codes, decorrelator state encodings and block limits.
// The frame decoder imports the same channel-mode constants.
package stereo_decorrelator_pkg;

  localparam logic [3:0] CH_MONO       = 4'd0;
  localparam logic [3:0] CH_INDEP      = 4'd1;
  localparam logic [3:0] CH_LEFT_SIDE  = 4'd8;
  localparam logic [3:0] CH_RIGHT_SIDE = 4'd9;
  localparam logic [3:0] CH_MID_SIDE   = 4'd10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CH0  = 2'd1;
  localparam logic [1:0] S_CH1  = 2'd2;

  localparam int MAX_BLOCK_DEFAULT = 4608;

  function automatic logic mode_supported(input logic [3:0] mode);
    return mode inside {CH_MONO, CH_INDEP, CH_LEFT_SIDE, CH_RIGHT_SIDE, CH_MID_SIDE};
  endfunction

endpackage

// File: rtl/stereo_decorrelator_sample_buffer.sv
// Channel-0 block store: single-port synchronous RAM, 1-cycle read latency.
// No backpressure; the caller never reads and writes in the same cycle.
module stereo_decorrelator_sample_buffer
  import stereo_decorrelator_pkg::*;
#(
  parameter int DATA_W = 17,
  parameter int DEPTH  = MAX_BLOCK_DEFAULT,
  parameter int ADDR_W = 13
) (
  input  logic              iClock,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge iClock) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/stereo_decorrelator.sv
// FLAC stereo decorrelator: buffers channel 0, pairs it with channel 1, emits L/R PCM.
// Latency 2 cycles from a channel-1 (or mono) sample; one pair per cycle, no backpressure.
module stereo_decorrelator
  import stereo_decorrelator_pkg::*;
#(
  parameter int DATA_W    = 17,
  parameter int OUT_W     = 16,
  parameter int MAX_BLOCK = MAX_BLOCK_DEFAULT,
  parameter int ADDR_W    = 13
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iFrameStart,
  input  logic [3:0]               iChannelMode,
  input  logic [15:0]              iBlockSize,
  input  logic                     iSampleValid,
  input  logic signed [DATA_W-1:0] iSample,
  output logic                     oSampleValid,
  output logic signed [OUT_W-1:0]  oLeft,
  output logic signed [OUT_W-1:0]  oRight,
  output logic                     oFrameDone,
  output logic                     oError
);

  localparam int W1 = DATA_W + 1;

  logic [1:0]              state;
  logic [3:0]              mode;
  logic [15:0]             block_size;
  logic [ADDR_W-1:0]       idx;
  logic                    frame_ok;
  logic                    last_idx;
  logic                    wr_en;
  logic                    rd_en;
  logic [DATA_W-1:0]       buf_rd;

  logic                    p_vld;
  logic                    p_last;
  logic [3:0]              p_mode;
  logic signed [DATA_W-1:0] p_b;

  logic signed [W1-1:0]    a;
  logic signed [W1-1:0]    b;
  logic signed [W1-1:0]    m;
  logic signed [W1-1:0]    sum;
  logic signed [W1-1:0]    dif;
  logic signed [W1-1:0]    l_nxt;
  logic signed [W1-1:0]    r_nxt;

  assign frame_ok = mode_supported(iChannelMode) && (iBlockSize != 16'd0)
                    && (int'(iBlockSize) <= MAX_BLOCK);
  assign last_idx = (16'(idx) == block_size - 16'd1);
  // A sample coinciding with a frame start belongs to no frame.
  assign wr_en    = iSampleValid && !iFrameStart && (state == S_CH0);
  assign rd_en    = iSampleValid && !iFrameStart && (state == S_CH1);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state      <= S_IDLE;
      mode       <= CH_MONO;
      block_size <= 16'd0;
      idx        <= '0;
      oError     <= 1'b0;
    end else if (iFrameStart) begin
      mode       <= iChannelMode;
      block_size <= iBlockSize;
      idx        <= '0;
      oError     <= !frame_ok;
      if (!frame_ok) begin
        state <= S_IDLE;
      end else if (iChannelMode == CH_MONO) begin
        state <= S_CH1;
      end else begin
        state <= S_CH0;
      end
    end else begin
      case (state)
        S_CH0: if (iSampleValid) begin
          idx   <= last_idx ? '0 : idx + 1'b1;
          state <= last_idx ? S_CH1 : S_CH0;
        end
        S_CH1: if (iSampleValid) begin
          idx   <= last_idx ? '0 : idx + 1'b1;
          state <= last_idx ? S_IDLE : S_CH1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  stereo_decorrelator_sample_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_BLOCK),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .iClock  (iClock),
    .addr    (idx),
    .wr_en   (wr_en),
    .wr_data (iSample),
    .rd_data (buf_rd)
  );

  // Mode travels with each sample so an abort cannot corrupt in-flight pairs.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      p_vld  <= 1'b0;
      p_last <= 1'b0;
      p_mode <= CH_MONO;
      p_b    <= '0;
    end else begin
      p_vld <= rd_en;
      if (rd_en) begin
        p_last <= last_idx;
        p_mode <= mode;
        p_b    <= iSample;
      end
    end
  end

  always_comb begin
    a   = {buf_rd[DATA_W-1], buf_rd};
    b   = {p_b[DATA_W-1], p_b};
    m   = (a << 1) | W1'(b[0]);
    sum = m + b;
    dif = m - b;
    l_nxt = a;
    r_nxt = b;
    case (p_mode)
      CH_MONO: begin
        l_nxt = b;
        r_nxt = b;
      end
      CH_LEFT_SIDE:  r_nxt = a - b;
      CH_RIGHT_SIDE: l_nxt = a + b;
      CH_MID_SIDE: begin
        l_nxt = sum >>> 1;
        r_nxt = dif >>> 1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      oSampleValid <= 1'b0;
      oFrameDone   <= 1'b0;
      oLeft        <= '0;
      oRight       <= '0;
    end else begin
      oSampleValid <= p_vld;
      oFrameDone   <= p_vld && p_last;
      if (p_vld) begin
        oLeft  <= OUT_W'(l_nxt);
        oRight <= OUT_W'(r_nxt);
      end
    end
  end

endmodule

// File: tb/tb_stereo_decorrelator.sv
// Self-checking bench for stereo_decorrelator: table vectors, corner sequences, random frames.
module tb_stereo_decorrelator;

  logic               iClock = 1'b0;
  logic               iReset;
  logic               iFrameStart;
  logic [3:0]         iChannelMode;
  logic [15:0]        iBlockSize;
  logic               iSampleValid;
  logic signed [16:0] iSample;
  logic               oSampleValid;
  logic signed [15:0] oLeft;
  logic signed [15:0] oRight;
  logic               oFrameDone;
  logic               oError;

  always #5 iClock = ~iClock;

  stereo_decorrelator dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .iFrameStart  (iFrameStart),
    .iChannelMode (iChannelMode),
    .iBlockSize   (iBlockSize),
    .iSampleValid (iSampleValid),
    .iSample      (iSample),
    .oSampleValid (oSampleValid),
    .oLeft        (oLeft),
    .oRight       (oRight),
    .oFrameDone   (oFrameDone),
    .oError       (oError)
  );

  typedef struct {
    int due;
    int l;
    int r;
    bit done;
  } exp_t;

  typedef struct packed {
    logic [3:0]        mode;
    logic [15:0]       size;
    logic              gp;
    logic [3:0][16:0]  ch0;
    logic [3:0][16:0]  ch1;
    logic [3:0][15:0]  el;
    logic [3:0][15:0]  er;
  } vec_t;

  exp_t q[$];
  vec_t tbl[6];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   f_ch0[4608];
  int   f_ch1[4608];
  int   f_l[4608];
  int   f_r[4608];
  int   modes[5] = '{0, 1, 8, 9, 10};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every cycle: either the scheduled pair is due, or the outputs must be quiet.
  task automatic tick();
    @(posedge iClock);
    #1;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      check("valid", int'(oSampleValid), 1);
      check("left", int'(oLeft), q[0].l);
      check("right", int'(oRight), q[0].r);
      check("frame_done", int'(oFrameDone), int'(q[0].done));
      void'(q.pop_front());
    end else begin
      check("valid_idle", int'(oSampleValid), 0);
      check("done_idle", int'(oFrameDone), 0);
    end
  endtask

  task automatic drive(input bit fs, input int mode, input int size, input bit v, input int s);
    iFrameStart  = fs;
    iChannelMode = 4'(mode);
    iBlockSize   = 16'(size);
    iSampleValid = v;
    iSample      = 17'(s);
    tick();
    iFrameStart  = 1'b0;
    iSampleValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  task automatic gaps(input int gmin, input int gmax);
    idle(int'($urandom_range(gmax, gmin)));
  endtask

  task automatic push(input int l, input int r, input bit done);
    exp_t e;
    e.due  = cyc + 2;
    e.l    = l;
    e.r    = r;
    e.done = done;
    q.push_back(e);
  endtask

  task automatic run_frame(input int mode, input int size, input int gmin, input int gmax);
    drive(1, mode, size, 0, 0);
    if (mode != 0) begin
      for (int i = 0; i < size; i++) begin
        gaps(gmin, gmax);
        drive(0, 0, 0, 1, f_ch0[i]);
      end
    end
    for (int i = 0; i < size; i++) begin
      gaps(gmin, gmax);
      push(f_l[i], f_r[i], i == size - 1);
      drive(0, 0, 0, 1, f_ch1[i]);
    end
  endtask

  task automatic flush();
    int n = 0;
    while (q.size() > 0 && n < 8) begin
      idle(1);
      n++;
    end
    check("drain", q.size(), 0);
    q.delete();
    idle(2);
  endtask

  // Reference: pick true L/R, encode per channel assignment, expect L/R back.
  task automatic gen_frame(input int mode, input int size);
    for (int i = 0; i < size; i++) begin
      int l = int'($urandom_range(65535, 0)) - 32768;
      int r = int'($urandom_range(65535, 0)) - 32768;
      f_l[i] = l;
      f_r[i] = r;
      case (mode)
        0:  begin f_ch0[i] = 0;            f_ch1[i] = l; f_r[i] = l; end
        1:  begin f_ch0[i] = l;            f_ch1[i] = r;     end
        8:  begin f_ch0[i] = l;            f_ch1[i] = l - r; end
        9:  begin f_ch0[i] = l - r;        f_ch1[i] = r;     end
        default: begin f_ch0[i] = (l + r) >>> 1; f_ch1[i] = l - r; end
      endcase
    end
  endtask

  task automatic set_vec(input int k, input int mode, input int size, input bit gp,
                         input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3,
                         input int l0, input int l1, input int l2, input int l3,
                         input int r0, input int r1, input int r2, input int r3);
    tbl[k].mode = 4'(mode);
    tbl[k].size = 16'(size);
    tbl[k].gp   = gp;
    tbl[k].ch0[0] = 17'(a0); tbl[k].ch0[1] = 17'(a1); tbl[k].ch0[2] = 17'(a2); tbl[k].ch0[3] = 17'(a3);
    tbl[k].ch1[0] = 17'(b0); tbl[k].ch1[1] = 17'(b1); tbl[k].ch1[2] = 17'(b2); tbl[k].ch1[3] = 17'(b3);
    tbl[k].el[0]  = 16'(l0); tbl[k].el[1]  = 16'(l1); tbl[k].el[2]  = 16'(l2); tbl[k].el[3]  = 16'(l3);
    tbl[k].er[0]  = 16'(r0); tbl[k].er[1]  = 16'(r1); tbl[k].er[2]  = 16'(r2); tbl[k].er[3]  = 16'(r3);
  endtask

  task automatic load_vec(input int k);
    for (int i = 0; i < 4; i++) begin
      f_ch0[i] = int'($signed(tbl[k].ch0[i]));
      f_ch1[i] = int'($signed(tbl[k].ch1[i]));
      f_l[i]   = int'($signed(tbl[k].el[i]));
      f_r[i]   = int'($signed(tbl[k].er[i]));
    end
  endtask

  task automatic run_vec(input int k);
    load_vec(k);
    run_frame(int'(tbl[k].mode), int'(tbl[k].size), tbl[k].gp ? 1 : 0, tbl[k].gp ? 3 : 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 50000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //      k mode size gp  ch0                    ch1                  expected L            expected R
    set_vec(0, 1, 4, 0,   1, 2, 3, 4,            10, 20, 30, 40,      1, 2, 3, 4,            10, 20, 30, 40);
    set_vec(1, 8, 2, 0,   100, -5, 0, 0,         30, -10, 0, 0,       100, -5, 0, 0,         70, 5, 0, 0);
    set_vec(2, 10, 2, 0,  3, -2, 0, 0,           1, -3, 0, 0,         4, -3, 0, 0,           3, 0, 0, 0);
    set_vec(3, 10, 2, 0,  32767, -32768, 0, 0,   0, 0, 0, 0,          32767, -32768, 0, 0,   32767, -32768, 0, 0);
    set_vec(4, 9, 2, 0,   5, -1, 0, 0,           -20, 32767, 0, 0,    -15, 32766, 0, 0,      -20, 32767, 0, 0);
    set_vec(5, 0, 3, 1,   0, 0, 0, 0,            7, -7, 0, 0,         7, -7, 0, 0,           7, -7, 0, 0);

    iReset = 1'b1; iFrameStart = 1'b0; iSampleValid = 1'b0;
    iChannelMode = 4'd0; iBlockSize = 16'd0; iSample = 17'd0;
    repeat (2) @(posedge iClock);
    #1;
    check("rst_valid", int'(oSampleValid), 0);
    check("rst_done", int'(oFrameDone), 0);
    check("rst_error", int'(oError), 0);
    check("rst_left", int'(oLeft), 0);
    check("rst_right", int'(oRight), 0);
    iReset = 1'b0;
    idle(2);

    for (int k = 0; k < 6; k++) begin
      run_vec(k);
      flush();
    end

    // Reserved mode and out-of-range block sizes: flag error, ignore samples.
    drive(1, 11, 4, 0, 0);
    check("err_mode", int'(oError), 1);
    repeat (4) drive(0, 0, 0, 1, int'($urandom_range(200, 1)));
    idle(3);
    drive(1, 1, 0, 0, 0);
    check("err_size0", int'(oError), 1);
    repeat (4) drive(0, 0, 0, 1, 9);
    idle(3);
    drive(1, 1, 4609, 0, 0);
    check("err_size4609", int'(oError), 1);
    repeat (8) drive(0, 0, 0, 1, 11);
    idle(3);
    check("err_sticky", int'(oError), 1);
    drive(1, 0, 1, 0, 0);
    check("err_clear", int'(oError), 0);
    push(123, 123, 1);
    drive(0, 0, 0, 1, 123);
    flush();

    // Abort after 2 of 4 channel-1 samples; in-flight pairs still emerge.
    load_vec(0);
    drive(1, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, f_ch0[i]);
    for (int i = 0; i < 2; i++) begin
      push(f_l[i], f_r[i], 0);
      drive(0, 0, 0, 1, f_ch1[i]);
    end
    run_vec(1);
    flush();

    // Asynchronous reset in the middle of channel 0, after outputs hold (4,40).
    run_vec(0);
    flush();
    drive(1, 1, 4, 0, 0);
    drive(0, 0, 0, 1, 5);
    drive(0, 0, 0, 1, 6);
    #2;
    iReset = 1'b1;
    #1;
    check("arst_valid", int'(oSampleValid), 0);
    check("arst_done", int'(oFrameDone), 0);
    check("arst_error", int'(oError), 0);
    check("arst_left", int'(oLeft), 0);
    check("arst_right", int'(oRight), 0);
    idle(1);
    iReset = 1'b0;
    idle(1);
    run_vec(2);
    flush();

    // Random frames, back to back, random gaps.
    for (int n = 0; n < 12; n++) begin
      int mode = modes[$urandom_range(4, 0)];
      int size = int'($urandom_range(48, 1));
      gen_frame(mode, size);
      run_frame(mode, size, 0, int'($urandom_range(2, 0)));
    end
    flush();

    // Largest legal block.
    drive(1, 10, 4608, 0, 0);
    check("max_block_ok", int'(oError), 0);
    gen_frame(10, 4608);
    run_frame(10, 4608, 0, 0);
    flush();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
